// File: rtl/invsqrt_nr_refine_pkg.sv
// Shared constants, widths and FSM states for the Newton-Raphson
// inverse square root refinement stage.
package invsqrt_pkg;

    localparam int X_W    = 23;
    localparam int Y_W    = 27;
    localparam int FRAC_W = 23;
    localparam int PROD_W = 2 * Y_W;

    // 1.5 in Q4.23
    localparam logic [Y_W-1:0] C_1P5 = 27'h0C00000;
    // Largest representable Q4.23 value, used as the saturation value
    localparam logic [Y_W-1:0] Y_MAX = 27'h7FFFFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        MXY  = 3'd2,
        SUB  = 3'd3,
        MUL  = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/invsqrt_qmul.sv
// Combinational Q4.23 x Q4.23 unsigned multiplier: floor to Q4.23 and
// saturate to Y_MAX whenever the integer part no longer fits in 4 bits.
module invsqrt_qmul
    import invsqrt_pkg::*;
(
    input  logic [Y_W-1:0] a,
    input  logic [Y_W-1:0] b,
    output logic [Y_W-1:0] p,
    output logic           sat
);

    logic [PROD_W-1:0] full;
    logic [PROD_W-1:0] shifted;

    // Full-width product, drop the extra fraction bits, then saturate on overflow
    always_comb begin
        full    = PROD_W'(a) * PROD_W'(b);
        shifted = full >> FRAC_W;
        sat     = |shifted[PROD_W-1:Y_W];
        p       = sat ? Y_MAX : shifted[Y_W-1:0];
    end

endmodule

// File: rtl/invsqrt_nr_refine.sv
// Newton-Raphson refinement of a coarse 1/sqrt(x) estimate:
//   y <= y * (1.5 - 0.5 * x * y * y), repeated ITERS times in Q4.23.
// One shared multiplier is time-multiplexed across SQ, MXY and MUL.
// Optional build macro INVSQRT_NR_SAT_FLAG_EN adds a registered sat_flag
// output reporting saturation, clamping or the x==0 shortcut.
module invsqrt_nr_refine
    import invsqrt_pkg::*;
#(
    parameter int ITERS = 2
) (
    input  logic           clk_p,
    input  logic           reset_n,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic           valid_in,
    output logic           in_ready,
    output logic [Y_W-1:0] y_out,
    output logic           out_valid
`ifdef INVSQRT_NR_SAT_FLAG_EN
    ,
    output logic           sat_flag
`endif
);

    localparam logic [1:0] LAST_ITER = 2'(ITERS - 1);

    state_e         state_q, state_d;
    logic [Y_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [Y_W-1:0] p_q, p_d;
    logic [1:0]     iter_q, iter_d;
    logic [Y_W-1:0] y_out_q, y_out_d;
    logic           out_valid_q, out_valid_d;

    logic [Y_W-1:0] mul_a, mul_b, mul_p;
    logic           mul_sat;
    logic signed [Y_W:0] s_wide;
    logic           sub_clamp;
    logic           last_iter;

    invsqrt_qmul u_qmul (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .sat (mul_sat)
    );

    assign last_iter = (iter_q == LAST_ITER);
    assign in_ready  = (state_q == IDLE);
    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;

    // Operand steering for the shared multiplier and the subtract/clamp step
    always_comb begin
        mul_a     = (state_q == MXY) ? x_q : y_q;
        mul_b     = (state_q == SQ) ? y_q : p_q;
        s_wide    = $signed({1'b0, C_1P5}) - $signed({2'b00, p_q[Y_W-1:1]});
        sub_clamp = s_wide[Y_W];
    end

    // Next-state and datapath update for the iteration sequencer
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        p_d         = p_q;
        iter_d      = iter_q;
        y_out_d     = y_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    x_d    = {{(Y_W - X_W){1'b0}}, x_in};
                    y_d    = y_in;
                    p_d    = '0;
                    iter_d = 2'd0;
                    if (x_in == '0) begin
                        state_d     = DONE;
                        y_out_d     = Y_MAX;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SQ;
                    end
                end
            end
            SQ: begin
                p_d     = mul_p;
                state_d = MXY;
            end
            MXY: begin
                p_d     = mul_p;
                state_d = SUB;
            end
            SUB: begin
                p_d     = sub_clamp ? '0 : s_wide[Y_W-1:0];
                state_d = MUL;
            end
            MUL: begin
                y_d = mul_p;
                if (last_iter) begin
                    state_d     = DONE;
                    y_out_d     = mul_p;
                    out_valid_d = 1'b1;
                end else begin
                    iter_d  = iter_q + 2'd1;
                    state_d = SQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and working registers, cleared by the asynchronous reset
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            iter_q      <= 2'd0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            p_q         <= p_d;
            iter_q      <= iter_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef INVSQRT_NR_SAT_FLAG_EN
    logic acc_q, acc_d;
    logic sat_flag_q, sat_flag_d;

    // Accumulate saturation/clamp events and publish them on entry to DONE
    always_comb begin
        acc_d      = acc_q;
        sat_flag_d = sat_flag_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    acc_d = (x_in == '0);
                    if (x_in == '0) begin
                        sat_flag_d = 1'b1;
                    end
                end
            end
            SQ, MXY: acc_d = acc_q | mul_sat;
            SUB:     acc_d = acc_q | sub_clamp;
            MUL: begin
                acc_d = acc_q | mul_sat;
                if (last_iter) begin
                    sat_flag_d = acc_q | mul_sat;
                end
            end
            default: acc_d = acc_q;
        endcase
    end

    // Flag registers share the datapath reset
    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    logic sat_unused;
    assign sat_unused = mul_sat | sub_clamp;
`endif

endmodule

// File: tb/tb_invsqrt_nr_refine.sv
// Directed, table-driven bench for invsqrt_nr_refine (ITERS=2), plus
// hand-written sequences for the ignored second operand and mid-op reset.
module tb_invsqrt_nr_refine;
    import invsqrt_pkg::*;

    logic           clk_p = 1'b0;
    logic           reset_n;
    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic           valid_in;
    logic           in_ready;
    logic [Y_W-1:0] y_out;
    logic           out_valid;
`ifdef INVSQRT_NR_SAT_FLAG_EN
    logic           sat_flag;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string          name;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [Y_W-1:0] exp_y;
        logic           exp_sat;
        int             exp_lat;
    } vec_t;

    vec_t           vecs[6];
    logic [Y_W-1:0] got_y[6];

    invsqrt_nr_refine #(.ITERS(2)) dut (
        .clk_p     (clk_p),
        .reset_n   (reset_n),
        .x_in      (x_in),
        .y_in      (y_in),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .y_out     (y_out),
        .out_valid (out_valid)
`ifdef INVSQRT_NR_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk_p = ~clk_p;

    // Reference Q4.23 multiply: floor, saturate on integer overflow
    function automatic logic [Y_W-1:0] ref_qmul(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        logic [53:0] f;
        logic [53:0] sh;
        f  = 54'(a) * 54'(b);
        sh = f >> 23;
        if (sh > 54'h7FFFFFF) return 27'h7FFFFFF;
        return sh[26:0];
    endfunction

    // Straight-line reference of the full refinement
    function automatic logic [Y_W-1:0] ref_refine(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input int iters);
        logic [Y_W-1:0] yy, y2, t;
        int s_i;
        if (x == 0) return 27'h7FFFFFF;
        yy = y;
        for (int i = 0; i < iters; i++) begin
            y2  = ref_qmul(yy, yy);
            t   = ref_qmul({4'b0000, x}, y2);
            s_i = 12582912 - int'(t >> 1);
            if (s_i < 0) s_i = 0;
            yy = ref_qmul(yy, 27'(s_i));
        end
        return yy;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one operand, measure latency and busy behaviour, check the result
    task automatic apply_stimulus(input vec_t v, output logic [Y_W-1:0] res);
        int   k;
        logic busy_ok;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk_p);
            #1;
            k++;
        end
        check_output({v.name, " ready"}, 32'(in_ready), 32'd1);
        @(negedge clk_p);
        x_in     = v.x;
        y_in     = v.y;
        valid_in = 1'b1;
        @(posedge clk_p);
        #1;
        valid_in = 1'b0;
        x_in     = X_W'($urandom);
        y_in     = Y_W'($urandom);
        k        = 0;
        busy_ok  = 1'b1;
        while (!out_valid && k < 20) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk_p);
            #1;
            k++;
        end
        res = y_out;
        check_output({v.name, " latency"}, 32'(k), 32'(v.exp_lat));
        check_output({v.name, " y_out"}, 32'(y_out), 32'(v.exp_y));
        check_output({v.name, " busy in_ready"}, 32'(busy_ok), 32'd1);
`ifdef INVSQRT_NR_SAT_FLAG_EN
        check_output({v.name, " sat_flag"}, 32'(sat_flag), 32'(v.exp_sat));
`endif
        @(posedge clk_p);
        #1;
        check_output({v.name, " pulse end"}, 32'(out_valid), 32'd0);
        check_output({v.name, " y_out hold"}, 32'(y_out), 32'(v.exp_y));
    endtask

    initial begin
        int             pulses;
        logic [Y_W-1:0] y_cap;
        int             diff;

        vecs[0] = '{"exact_2p0",  23'h200000, 27'h1000000, 27'h1000000, 1'b0, 8};
        vecs[1] = '{"near_1p34",  23'h473E47, 27'h0A66666, ref_refine(23'h473E47, 27'h0A66666, 2), 1'b0, 8};
        vecs[2] = '{"x_zero",     23'h000000, 27'h0A66666, 27'h7FFFFFF, 1'b1, 0};
        vecs[3] = '{"clamp",      23'h7EB851, 27'h7800000, 27'h0000000, 1'b1, 8};
        vecs[4] = '{"y_zero",     23'h200000, 27'h0000000, 27'h0000000, 1'b0, 8};
        vecs[5] = '{"from_1p0",   23'h200000, 27'h0800000, 27'h0DE6800, 1'b0, 8};

        reset_n  = 1'b0;
        valid_in = 1'b0;
        x_in     = '0;
        y_in     = '0;
        #1;
        check_output("reset y_out", 32'(y_out), 32'd0);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd1);
`ifdef INVSQRT_NR_SAT_FLAG_EN
        check_output("reset sat_flag", 32'(sat_flag), 32'd0);
`endif
        repeat (2) @(negedge clk_p);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], got_y[i]);
        end

        // Loose window around the nominal 1.340383 * 2^23 result
        diff = int'(got_y[1]) - 11243948;
        if (diff < 0) diff = -diff;
        check_output("near_1p34 window", 32'(diff <= 128), 32'd1);

        // Second valid_in while the block is in MXY must be ignored
        @(negedge clk_p);
        x_in     = 23'h200000;
        y_in     = 27'h0800000;
        valid_in = 1'b1;
        @(posedge clk_p);
        #1;
        valid_in = 1'b0;
        @(posedge clk_p);
        #1;
        x_in     = 23'h200000;
        y_in     = 27'h1000000;
        valid_in = 1'b1;
        @(posedge clk_p);
        #1;
        valid_in = 1'b0;
        pulses   = 0;
        y_cap    = '0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                pulses++;
                y_cap = y_out;
            end
            @(posedge clk_p);
            #1;
        end
        check_output("drop pulses", 32'(pulses), 32'd1);
        check_output("drop y_out", 32'(y_cap), 32'h0DE6800);
        check_output("drop in_ready", 32'(in_ready), 32'd1);

        // Reset pulled low while in SUB aborts the operation
        @(negedge clk_p);
        x_in     = 23'h200000;
        y_in     = 27'h1000000;
        valid_in = 1'b1;
        @(posedge clk_p);
        #1;
        valid_in = 1'b0;
        @(posedge clk_p);
        @(posedge clk_p);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("abort y_out", 32'(y_out), 32'd0);
        check_output("abort out_valid", 32'(out_valid), 32'd0);
        check_output("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk_p);
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_p);
            #1;
            if (out_valid) pulses++;
        end
        check_output("abort no pulse", 32'(pulses), 32'd0);
        check_output("abort idle", 32'(in_ready), 32'd1);

        apply_stimulus(vecs[5], got_y[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
